// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan sweeper: FSM states, sizes and the
// saturating error accumulator used when a vector is checked.
package demorgan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int ERR_W       = 4;
    localparam int MAP_W       = 8;
    localparam int CNT_W       = 4;

    localparam logic [ERR_W-1:0] ERR_MAX = 4'd8;

    // Add 0..2 new law failures to the running count, clamping at ERR_MAX.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] count,
                                                 input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, count} + {3'b000, inc};
        return (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/demorgan_settle_timer.sv
// Settle timer: counts the SETTLE cycles of the current vector and flags
// when SETTLE_CYCLES of them have elapsed.
module demorgan_settle_timer
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] settle_cnt;

    // The counter holds the number of the current SETTLE cycle, so load starts it at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (load) begin
            settle_cnt <= CNT_W'(1);
        end else if (count && !expired) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    assign expired = (settle_cnt == LIMIT);

endmodule

// File: rtl/demorgan_sweeper.sv
// De Morgan sweeper: drives A/B through 00,01,10,11, lets the external
// demorgan stage settle, then checks both laws and accumulates failures.
// Optional feature: define DEMORGAN_SWEEP_LOG_EN to add the fail_map output,
// which records which law failed on which vector.
module demorgan_sweeper
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             nAandnB,
    input  logic             nAorB,
    input  logic             nAornB,
    input  logic             nAandB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef DEMORGAN_SWEEP_LOG_EN
    ,
    output logic [MAP_W-1:0] fail_map
`endif
);

    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] vec_idx;
    logic       timer_load;
    logic       settle_expired;
    logic       accept;
    logic       ideal_nor;
    logic       ideal_nand;
    logic       law1_fail;
    logic       law2_fail;
    logic [ERR_W-1:0] err_next;

    demorgan_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .count  (state == SETTLE),
        .expired(settle_expired)
    );

    assign A = vec_idx[1];
    assign B = vec_idx[0];

    assign accept     = (state == IDLE) && start;
    assign ideal_nor  = ~(A | B);
    assign ideal_nand = ~(A & B);
    assign law1_fail  = (nAandnB != ideal_nor) || (nAorB != ideal_nor);
    assign law2_fail  = (nAornB != ideal_nand) || (nAandB != ideal_nand);
    assign err_next   = sat_add(err_count, {1'b0, law1_fail} + {1'b0, law2_fail});

    // State register; reset overrides everything, including a pending start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the busy/done flags and the settle timer reload.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_expired) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (vec_idx != LAST_VEC) begin
                    state_next = SETTLE;
                    timer_load = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep datapath: vector index, error count and the pass verdict; all hold after DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_idx   <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            vec_idx   <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else if (state == CHECK) begin
            err_count <= err_next;
            if (vec_idx != LAST_VEC) begin
                vec_idx <= vec_idx + 2'd1;
            end else begin
                pass <= (err_next == '0);
            end
        end
    end

`ifdef DEMORGAN_SWEEP_LOG_EN
    // Record law-1 in bit 2*v and law-2 in bit 2*v+1 for the vector being checked.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            fail_map <= '0;
        end else if (state == CHECK) begin
            fail_map[{vec_idx, 1'b0}] <= law1_fail;
            fail_map[{vec_idx, 1'b1}] <= law2_fail;
        end
    end
`endif

endmodule

// File: tb/tb_demorgan_sweeper.sv
// Self-checking bench for demorgan_sweeper. A behavioural demorgan stage with
// configurable faults is attached; expected results come from a truth-table
// model of the two laws. Build with DEMORGAN_SWEEP_LOG_EN to also check fail_map.
module tb_demorgan_sweeper;

    logic clk = 1'b0;
    logic reset;
    logic start, start1, start15;

    logic A, B, nAandnB, nAorB, nAornB, nAandB, busy, done, pass;
    logic [3:0] err_count;
    logic A1, B1, nAandnB1, nAorB1, nAornB1, nAandB1, busy1, done1, pass1;
    logic [3:0] err_count1;
    logic A15, B15, nAandnB15, nAorB15, nAornB15, nAandB15, busy15, done15, pass15;
    logic [3:0] err_count15;
`ifdef DEMORGAN_SWEEP_LOG_EN
    logic [7:0] fail_map, fail_map1, fail_map15;
`endif

    // Fault injection for the stage attached to the main DUT.
    logic [15:0] flip;
    logic [3:0]  stuck0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stage model: ideal NOR/NAND values per vector, then flips and stuck-at-0 faults.
    // Output order: [0]=nAandnB [1]=nAorB [2]=nAornB [3]=nAandB.
    function automatic logic [3:0] stage_out(input logic [1:0] v, input logic [15:0] fl,
                                             input logic [3:0] st);
        logic       t_nor, t_nand;
        logic [3:0] o;
        int         idx;
        t_nor  = (v == 2'b00);
        t_nand = (v != 2'b11);
        idx    = 4 * int'(v);
        o      = {t_nand, t_nand, t_nor, t_nor} ^ fl[idx +: 4];
        return o & ~st;
    endfunction

    assign {nAandB, nAornB, nAorB, nAandnB}         = stage_out({A, B}, flip, stuck0);
    assign {nAandB1, nAornB1, nAorB1, nAandnB1}     = stage_out({A1, B1}, 16'h0, 4'h0);
    assign {nAandB15, nAornB15, nAorB15, nAandnB15} = stage_out({A15, B15}, 16'h0, 4'h0);

    demorgan_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .nAandnB(nAandnB), .nAorB(nAorB), .nAornB(nAornB), .nAandB(nAandB),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef DEMORGAN_SWEEP_LOG_EN
        , .fail_map(fail_map)
`endif
    );

    demorgan_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .A(A1), .B(B1),
        .nAandnB(nAandnB1), .nAorB(nAorB1), .nAornB(nAornB1), .nAandB(nAandB1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1)
`ifdef DEMORGAN_SWEEP_LOG_EN
        , .fail_map(fail_map1)
`endif
    );

    demorgan_sweeper #(.SETTLE_CYCLES(15)) dut15 (
        .clk(clk), .reset(reset), .start(start15), .A(A15), .B(B15),
        .nAandnB(nAandnB15), .nAorB(nAorB15), .nAornB(nAornB15), .nAandB(nAandB15),
        .busy(busy15), .done(done15), .pass(pass15), .err_count(err_count15)
`ifdef DEMORGAN_SWEEP_LOG_EN
        , .fail_map(fail_map15)
`endif
    );

    // Reset holds all outputs at zero even while start is requested.
    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start1 = 1'b0; start15 = 1'b0;
        flip = 16'h0; stuck0 = 4'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_cmp++; if ({A, B} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_ab got %b want 00", {A, B}); end
        n_cmp++; if (err_count !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_err got %0d want 0", err_count); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pass got %b want 0", pass); end
`ifdef DEMORGAN_SWEEP_LOG_EN
        n_cmp++; if (fail_map !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_map got %h want 00", fail_map); end
`endif
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
    endtask

    // One full sweep on the SETTLE_CYCLES=2 DUT, checked cycle by cycle against the law model.
    task automatic run_sweep(input string tag);
        int         exp_err;
        logic [7:0] exp_map;
        logic [3:0] o;
        logic       f1, f2;
        int         n, v;
        exp_err = 0; exp_map = 8'h00;
        for (int vv = 0; vv < 4; vv++) begin
            o  = stage_out(2'(vv), flip, stuck0);
            f1 = (o[0] != (vv == 0)) || (o[1] != (vv == 0));
            f2 = (o[2] != (vv != 3)) || (o[3] != (vv != 3));
            exp_err += int'(f1) + int'(f2);
            exp_map[2*vv]   = f1;
            exp_map[2*vv+1] = f2;
        end
        if (exp_err > 8) exp_err = 8;
        n = 4 * (2 + 1) + 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            v = (k - 1) / 3;
            if (v > 3) v = 3;
            n_cmp++; if ({A, B} !== 2'(v)) begin n_bad++; $display("[TB] FAIL %s_ab c%0d got %b want %b", tag, k, {A, B}, 2'(v)); end
            n_cmp++; if (done !== (k == n)) begin n_bad++; $display("[TB] FAIL %s_done c%0d got %b want %b", tag, k, done, (k == n)); end
            n_cmp++; if (busy !== (k < n)) begin n_bad++; $display("[TB] FAIL %s_busy c%0d got %b want %b", tag, k, busy, (k < n)); end
            if (k == 1) begin
                n_cmp++; if (err_count !== 4'd0) begin n_bad++; $display("[TB] FAIL %s_err_clear got %0d want 0", tag, err_count); end
                n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("[TB] FAIL %s_pass_clear got %b want 0", tag, pass); end
            end
            if (k >= n) begin
                n_cmp++; if (err_count !== 4'(exp_err)) begin n_bad++; $display("[TB] FAIL %s_err c%0d got %0d want %0d", tag, k, err_count, exp_err); end
                n_cmp++; if (pass !== (exp_err == 0)) begin n_bad++; $display("[TB] FAIL %s_pass c%0d got %b want %b", tag, k, pass, (exp_err == 0)); end
`ifdef DEMORGAN_SWEEP_LOG_EN
                n_cmp++; if (fail_map !== exp_map) begin n_bad++; $display("[TB] FAIL %s_map c%0d got %h want %h", tag, k, fail_map, exp_map); end
`endif
            end
            @(negedge clk);
        end
    endtask

    // Healthy stage: pass with no errors.
    task automatic test_golden();
        flip = 16'h0; stuck0 = 4'h0;
        run_sweep("golden");
    endtask

    // nAorB stuck at 0: only law-1 on vector 00 fails.
    task automatic test_stuck();
        flip = 16'h0; stuck0 = 4'b0010;
        run_sweep("stuck");
    endtask

    // Every stage output inverted: both laws fail everywhere.
    task automatic test_inverted();
        flip = 16'hFFFF; stuck0 = 4'h0;
        run_sweep("inverted");
    endtask

    // Random per-vector faults.
    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            flip   = 16'($urandom);
            stuck0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            run_sweep($sformatf("rand%0d", i));
        end
    endtask

    // Reset in cycle 5 aborts the sweep with no done pulse; a new sweep then works.
    task automatic test_mid_reset();
        int seen;
        flip = 16'hFFFF; stuck0 = 4'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k < 5; k++) @(negedge clk);
        n_cmp++; if (err_count !== 4'd2) begin n_bad++; $display("[TB] FAIL midrst_err_before got %0d want 2", err_count); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if ({A, B} !== 2'b00) begin n_bad++; $display("[TB] FAIL midrst_ab got %b want 00", {A, B}); end
        n_cmp++; if (err_count !== 4'd0) begin n_bad++; $display("[TB] FAIL midrst_err got %0d want 0", err_count); end
        seen = (done === 1'b1) ? 1 : 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", seen); end
        flip = 16'h0;
        run_sweep("after_reset");
    endtask

    // Second pulse during busy is ignored; start held over DONE relaunches from the first IDLE cycle.
    task automatic test_back_to_back();
        int n;
        n = 13;
        flip = 16'h0; stuck0 = 4'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 2 * n + 2; k++) begin
            n_cmp++; if (done !== (k == n || k == 2 * n + 1)) begin n_bad++; $display("[TB] FAIL b2b_done c%0d got %b want %b", k, done, (k == n || k == 2 * n + 1)); end
            n_cmp++; if (busy !== (k < n || (k >= n + 2 && k < 2 * n + 1))) begin n_bad++; $display("[TB] FAIL b2b_busy c%0d got %b", k, busy); end
            if (k == n) begin
                n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_pass1 got %b want 1", pass); end
            end
            if (k == n + 2) begin
                n_cmp++; if ({A, B} !== 2'b00) begin n_bad++; $display("[TB] FAIL b2b_ab_relaunch got %b want 00", {A, B}); end
                n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_pass_clear got %b want 0", pass); end
            end
            start = (k == 4) || (k >= n - 1 && k < 2 * n + 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Done latency for SETTLE_CYCLES of 1 and 15.
    task automatic test_latency();
        int cnt;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cnt = 1;
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("[TB] FAIL lat1_busy got %b want 1", busy1); end
        while (done1 !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        n_cmp++; if (cnt != 9) begin n_bad++; $display("[TB] FAIL lat1 got %0d want 9", cnt); end
        n_cmp++; if (pass1 !== 1'b1 || err_count1 !== 4'd0) begin n_bad++; $display("[TB] FAIL lat1_result pass %b err %0d want 1/0", pass1, err_count1); end

        @(negedge clk); start15 = 1'b1;
        @(negedge clk); start15 = 1'b0;
        cnt = 1;
        n_cmp++; if (busy15 !== 1'b1) begin n_bad++; $display("[TB] FAIL lat15_busy got %b want 1", busy15); end
        while (done15 !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        n_cmp++; if (cnt != 65) begin n_bad++; $display("[TB] FAIL lat15 got %0d want 65", cnt); end
        n_cmp++; if (pass15 !== 1'b1 || err_count15 !== 4'd0) begin n_bad++; $display("[TB] FAIL lat15_result pass %b err %0d want 1/0", pass15, err_count15); end
    endtask

    // Top-level sequence of scenarios.
    initial begin
        test_reset();
        test_golden();
        test_stuck();
        test_inverted();
        test_random();
        test_mid_reset();
        test_back_to_back();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired after %0d compared", n_cmp);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/demorgan_sweeper.md
DEMORGAN_SWEEPER -- requirements
Module: demorgan_sweeper

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, cycles A/B are held before outputs are sampled; legal range 1..15.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request one sweep; sampled only in IDLE.
REQ-006 A  output  1  stimulus A to the demorgan stage.
REQ-007 B  output  1  stimulus B to the demorgan stage.
REQ-008 nAandnB  input  1  ~A&~B returned by the demorgan stage.
REQ-009 nAorB  input  1  ~(A|B) returned by the demorgan stage.
REQ-010 nAornB  input  1  ~A|~B returned by the demorgan stage.
REQ-011 nAandB  input  1  ~(A&B) returned by the demorgan stage.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse at end of sweep.
REQ-014 pass  output  1  high when the last completed sweep had zero errors; held until next accepted start.
REQ-015 err_count  output  4  total law failures in the current/last sweep (0..8).

Function
REQ-016 FSM states IDLE, SETTLE, CHECK, DONE; IDLE->SETTLE on start; SETTLE->CHECK when settle counter reaches SETTLE_CYCLES; CHECK->SETTLE if vector index <3 else CHECK->DONE; DONE->IDLE unconditionally.
REQ-017 Vectors driven in order {A,B} = 00, 01, 10, 11; vector index is 2 bits, increments only on CHECK->SETTLE, never wraps within a sweep.
REQ-018 On accepting start, err_count and pass clear to 0 and {A,B}=00 in the same edge.
REQ-019 Each vector occupies exactly SETTLE_CYCLES SETTLE cycles plus one CHECK cycle; A/B are stable for all of them.
REQ-020 In CHECK: law-1 fails if nAandnB or nAorB differs from ~(A|B); law-2 fails if nAornB or nAandB differs from ~(A&B); err_count increments by the number of failing laws (0, 1 or 2) per vector.
REQ-021 done asserts exactly 4*(SETTLE_CYCLES+1)+1 cycles after the edge at which start is sampled high in IDLE; pass updates to (err_count==0) in the same cycle done is high.
REQ-022 start while busy or in DONE is ignored; start held high continuously re-launches a sweep from each IDLE cycle.
REQ-023 err_count saturates at 8 and never wraps.
REQ-024 After done, A, B, err_count and pass hold their values until the next accepted start.

Reset
REQ-025 reset takes priority over all events including start, in any state, and returns the FSM to IDLE on the next edge.
REQ-026 Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, vector index=0, settle counter=0.
REQ-027 Reset mid-sweep discards the partial sweep; no done pulse is produced for it.

Configuration
REQ-028 Macro DEMORGAN_SWEEP_LOG_EN: when defined, adds output fail_map (8 bits), bit 2*v set if law-1 failed on vector v, bit 2*v+1 if law-2 failed; cleared on accepted start and reset.
REQ-029 Without DEMORGAN_SWEEP_LOG_EN the fail_map port and its logic do not exist; all other behaviour is identical.

Structure
REQ-030 Shared package demorgan_pkg holds the FSM state enum, NUM_VECTORS=4, ERR_W=4 and MAP_W=8.
REQ-031 One sub-module demorgan_settle_timer: load/count/expired for the SETTLE_CYCLES counter; all else stays in demorgan_sweeper.

Verification
REQ-032 Correct demorgan stage attached, SETTLE_CYCLES=2, start pulse -> done exactly 13 cycles later, pass=1, err_count=0, A/B visit 00,01,10,11.
REQ-033 nAorB stuck at 0 -> law-1 fails on vector 00 only -> err_count=1, pass=0 (fail_map=8'h01 with DEMORGAN_SWEEP_LOG_EN).
REQ-034 All four inputs inverted -> both laws fail on all vectors -> err_count=8, pass=0 (fail_map=8'hFF).
REQ-035 reset asserted in cycle 5 of a sweep -> next cycle busy=0, A=B=0, err_count=0, no done pulse; new start then completes normally.
REQ-036 start pulsed again during busy and held high across DONE -> second pulse ignored, held start launches next sweep in first IDLE cycle after DONE.
REQ-037 SETTLE_CYCLES=1 and 15 -> done latency 9 and 65 cycles respectively.
